// File: rtl/exec_wb.sv
// Execute/write-back stage: one ALU or shift operation per request, with the result
// and its condition codes handed to the register file through a one-cycle write strobe.
module exec_wb #(
  parameter int unsigned SERIAL_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        imm_sel,
  input  logic [4:0]  imm5,
  input  logic [1:0]  shf_mode,
  input  logic [3:0]  amount,
  input  logic [2:0]  dst,
  input  logic [15:0] sr1_val,
  input  logic [15:0] sr2_val,
  output logic        ready,
  output logic        take_data,
  output logic [2:0]  dr,
  output logic [15:0] dr_in,
  output logic [2:0]  nzp,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] M_LSHF = 2'b00;
  localparam logic [1:0] M_RSHA = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] val_q, val_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  dst_q, dst_d;
  logic        take_q, take_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] dr_in_q, dr_in_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] opb;

  function automatic logic [15:0] shift_one(input logic [15:0] v, input logic [1:0] m);
    if (m == M_LSHF)      return {v[14:0], 1'b0};
    else if (m == M_RSHA) return {v[15], v[15:1]};
    else                  return {1'b0, v[15:1]};
  endfunction

  function automatic logic [15:0] shift_full(input logic [15:0] v, input logic [1:0] m,
                                             input logic [3:0] n);
    if (m == M_LSHF)      return v << n;
    else if (m == M_RSHA) return 16'($signed(v) >>> n);
    else                  return v >> n;
  endfunction

  function automatic logic [2:0] cond_codes(input logic [15:0] r);
    if (r[15])           return 3'b100;
    else if (r == 16'd0) return 3'b010;
    else                 return 3'b001;
  endfunction

  assign opb = imm_sel ? {{11{imm5[4]}}, imm5} : sr2_val;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dst_d   = dst_q;
    take_d  = 1'b0;
    dr_d    = dr_q;
    dr_in_d = dr_in_q;
    nzp_d   = nzp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dst_d   = dst;
          mode_d  = shf_mode;
          state_d = WB;
          case (op)
            OP_ADD: val_d = sr1_val + opb;
            OP_AND: val_d = sr1_val & opb;
            OP_XOR: val_d = sr1_val ^ opb;
            default: begin
              // Serial shifts step the raw operand; everything else lands in WB finished.
              if (SERIAL_SHIFT != 0 && amount != 4'd0) begin
                val_d   = sr1_val;
                cnt_d   = amount;
                state_d = SHIFT;
              end else begin
                val_d = shift_full(sr1_val, shf_mode, amount);
              end
            end
          endcase
        end
      end
      SHIFT: begin
        val_d = shift_one(val_q, mode_q);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = WB;
      end
      WB: begin
        take_d  = 1'b1;
        dr_d    = dst_q;
        dr_in_d = val_q;
        nzp_d   = cond_codes(val_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= 16'd0;
      cnt_q   <= 4'd0;
      mode_q  <= 2'd0;
      dst_q   <= 3'd0;
      take_q  <= 1'b0;
      dr_q    <= 3'd0;
      dr_in_q <= 16'd0;
      nzp_q   <= 3'b010;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dst_q   <= dst_d;
      take_q  <= take_d;
      dr_q    <= dr_d;
      dr_in_q <= dr_in_d;
      nzp_q   <= nzp_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign take_data = take_q;
  assign dr        = dr_q;
  assign dr_in     = dr_in_q;
  assign nzp       = nzp_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exec_wb.sv
// Bench for exec_wb: a serial-shift and a one-cycle-shift instance share every input
// and are checked against an arithmetic model of the operation set.
module tb_exec_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        imm_sel = 1'b0;
  logic [4:0]  imm5 = 5'd0;
  logic [1:0]  shf_mode = 2'd0;
  logic [3:0]  amount = 4'd0;
  logic [2:0]  dst = 3'd0;
  logic [15:0] sr1_val = 16'd0;
  logic [15:0] sr2_val = 16'd0;

  logic        ready_w[2];
  logic        take_w[2];
  logic [2:0]  dr_w[2];
  logic [15:0] dr_in_w[2];
  logic [2:0]  nzp_w[2];
  logic [1:0]  st_w[2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Index 0: serial shifter, index 1: single-cycle shifter.
  exec_wb #(.SERIAL_SHIFT(1)) u_ser (
    .clk(clk), .rst(rst), .start(start), .op(op), .imm_sel(imm_sel), .imm5(imm5),
    .shf_mode(shf_mode), .amount(amount), .dst(dst), .sr1_val(sr1_val), .sr2_val(sr2_val),
    .ready(ready_w[0]), .take_data(take_w[0]), .dr(dr_w[0]), .dr_in(dr_in_w[0]),
    .nzp(nzp_w[0]), .state_dbg(st_w[0]));

  exec_wb #(.SERIAL_SHIFT(0)) u_par (
    .clk(clk), .rst(rst), .start(start), .op(op), .imm_sel(imm_sel), .imm5(imm5),
    .shf_mode(shf_mode), .amount(amount), .dst(dst), .sr1_val(sr1_val), .sr2_val(sr2_val),
    .ready(ready_w[1]), .take_data(take_w[1]), .dr(dr_w[1]), .dr_in(dr_in_w[1]),
    .nzp(nzp_w[1]), .state_dbg(st_w[1]));

  function automatic logic [15:0] model(input logic [1:0] o, input logic is_imm,
                                        input logic [4:0] i5, input logic [15:0] a,
                                        input logic [15:0] b2, input logic [1:0] m,
                                        input logic [3:0] n);
    int b, r, sa;
    b = is_imm ? (int'($signed(i5)) & 32'hFFFF) : int'(b2);
    case (o)
      2'd0: r = (int'(a) + b) % 65536;
      2'd1: r = int'(a) & b;
      2'd2: r = int'(a) ^ b;
      default: begin
        if (m == 2'b00) r = (int'(a) * (1 << n)) % 65536;
        else if (m == 2'b11) begin
          sa = int'($signed(a));
          r  = (sa >>> n) & 32'hFFFF;
        end else r = int'(a) / (1 << n);
      end
    endcase
    return r[15:0];
  endfunction

  function automatic logic [2:0] model_nzp(input logic [15:0] r);
    if (r >= 16'h8000) return 3'b100;
    if (r == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic scramble();
    op = 2'($urandom); imm_sel = 1'($urandom); imm5 = 5'($urandom);
    shf_mode = 2'($urandom); amount = 4'($urandom); dst = 3'($urandom);
    sr1_val = 16'($urandom); sr2_val = 16'($urandom);
  endtask

  // Called at a negedge with both instances idle; returns at a negedge.
  task automatic run_op(input string name, input logic [1:0] o, input logic is_imm,
                        input logic [4:0] i5, input logic [1:0] m, input logic [3:0] n,
                        input logic [2:0] d3, input logic [15:0] a, input logic [15:0] b2);
    logic [15:0] exp_v, got_v[2];
    logic [2:0]  got_dr[2], got_nzp[2];
    int lat[2], first[2], pulses[2], rlow[2];
    exp_v = model(o, is_imm, i5, a, b2, m, n);
    lat[0] = (o == 2'd3 && n != 4'd0) ? int'(n) + 2 : 2;
    lat[1] = 2;
    for (int d = 0; d < 2; d++) begin
      first[d] = -1; pulses[d] = 0; rlow[d] = 0;
      got_v[d] = '0; got_dr[d] = '0; got_nzp[d] = '0;
      n_checks++;
      if (ready_w[d] !== 1'b1) $display("FAIL %s dut%0d ready_before got=%b exp=1", name, d, ready_w[d]);
      else n_pass++;
    end
    op = o; imm_sel = is_imm; imm5 = i5; shf_mode = m; amount = n; dst = d3;
    sr1_val = a; sr2_val = b2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int c = 0; c < 20; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (ready_w[d] !== 1'b1) rlow[d]++;
        if (take_w[d] === 1'b1) begin
          pulses[d]++;
          if (first[d] < 0) begin
            first[d] = c; got_v[d] = dr_in_w[d]; got_dr[d] = dr_w[d]; got_nzp[d] = nzp_w[d];
          end
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (pulses[d] != 1) $display("FAIL %s dut%0d pulses got=%0d exp=1", name, d, pulses[d]);
      else n_pass++;
      n_checks++;
      if (first[d] != lat[d] - 1) $display("FAIL %s dut%0d latency got=%0d exp=%0d", name, d, first[d], lat[d] - 1);
      else n_pass++;
      n_checks++;
      if (rlow[d] != lat[d] - 1) $display("FAIL %s dut%0d ready_low got=%0d exp=%0d", name, d, rlow[d], lat[d] - 1);
      else n_pass++;
      n_checks++;
      if (got_v[d] !== exp_v || got_dr[d] !== d3 || got_nzp[d] !== model_nzp(exp_v))
        $display("FAIL %s dut%0d result got=%h/%0d/%b exp=%h/%0d/%b", name, d,
                 got_v[d], got_dr[d], got_nzp[d], exp_v, d3, model_nzp(exp_v));
      else n_pass++;
      n_checks++;
      if (dr_in_w[d] !== exp_v) $display("FAIL %s dut%0d hold got=%h exp=%h", name, d, dr_in_w[d], exp_v);
      else n_pass++;
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (ready_w[d] !== 1'b1 || take_w[d] !== 1'b0 || dr_w[d] !== 3'd0 ||
          dr_in_w[d] !== 16'h0000 || nzp_w[d] !== 3'b010)
        $display("FAIL %s dut%0d got=%b/%b/%0d/%h/%b exp=1/0/0/0000/010", name, d,
                 ready_w[d], take_w[d], dr_w[d], dr_in_w[d], nzp_w[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset_state("reset");
    // A start under reset must leave nothing behind.
    rst = 1'b1; start = 1'b1; op = 2'd0; sr1_val = 16'h1234;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_state("reset_over_start");
  endtask

  task automatic test_directed();
    run_op("add_ovf",    2'd0, 1'b1, 5'b00001, 2'd0, 4'd0,  3'd1, 16'h7FFF, 16'h0000);
    run_op("and_zero",   2'd1, 1'b0, 5'd0,     2'd0, 4'd0,  3'd5, 16'h00F0, 16'h0F0F);
    run_op("rshfa_4",    2'd3, 1'b0, 5'd0,     2'b11, 4'd4, 3'd2, 16'h8001, 16'h0000);
    run_op("lshf_15",    2'd3, 1'b0, 5'd0,     2'b00, 4'd15, 3'd3, 16'h0001, 16'h0000);
    run_op("lshf_0",     2'd3, 1'b0, 5'd0,     2'b00, 4'd0, 3'd4, 16'h0001, 16'h0000);
    run_op("add_neg3",   2'd0, 1'b1, 5'b11101, 2'd0, 4'd0,  3'd6, 16'h0003, 16'h0000);
    run_op("mode10",     2'd3, 1'b0, 5'd0,     2'b10, 4'd3, 3'd7, 16'h8000, 16'h0000);
    run_op("xor",        2'd2, 1'b0, 5'd0,     2'd0, 4'd0,  3'd0, 16'hA5A5, 16'h0F0F);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op("random", 2'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
             4'($urandom_range(0, 15)), 3'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v;
    logic [1:0]  o;
    logic [2:0]  d3;
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (ready_w[d] !== 1'b1) $display("FAIL b2b_ready dut%0d got=%b exp=1", d, ready_w[d]);
        else n_pass++;
      end
      scramble();
      o = 2'($urandom_range(0, 2)); op = o; d3 = dst; start = 1'b1;
      exp_v = model(o, imm_sel, imm5, sr1_val, sr2_val, shf_mode, amount);
      @(negedge clk);
      scramble();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (ready_w[d] !== 1'b0) $display("FAIL b2b_busy dut%0d got=%b exp=0", d, ready_w[d]);
        else n_pass++;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (take_w[d] !== 1'b1 || dr_in_w[d] !== exp_v || dr_w[d] !== d3)
          $display("FAIL b2b_result dut%0d got=%b/%h/%0d exp=1/%h/%0d", d, take_w[d], dr_in_w[d], dr_w[d], exp_v, d3);
        else n_pass++;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int pulses, first;
    logic [15:0] a, exp_v;
    a = 16'($urandom);
    exp_v = model(2'd3, 1'b0, 5'd0, a, 16'd0, 2'b01, 4'd6);
    pulses = 0; first = -1;
    op = 2'd3; shf_mode = 2'b01; amount = 4'd6; dst = 3'd3; sr1_val = a; start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (c < 6) begin scramble(); start = 1'b1; end
      else start = 1'b0;
      if (take_w[0] === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
        if (first == c) begin
          n_checks++;
          if (dr_in_w[0] !== exp_v) $display("FAIL ignore_result got=%h exp=%h", dr_in_w[0], exp_v);
          else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 1 || first != 7) $display("FAIL ignore_pulses got=%0d@%0d exp=1@7", pulses, first);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int pulses;
    pulses = 0;
    op = 2'd3; shf_mode = 2'b00; amount = 4'd10; sr1_val = 16'h0101; dst = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset_mid_shift");
    for (int c = 0; c < 15; c++) begin
      if (take_w[0] === 1'b1 || take_w[1] === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0 || nzp_w[0] !== 3'b010) $display("FAIL reset_abort got=%0d/%b exp=0/010", pulses, nzp_w[0]);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
